// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : hilo_muldiv_pkg
// Brief  : Op encodings and helpers shared by the HI/LO multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } md_op_e;

  localparam logic [3:0] ALU_CTRL_MULTU = 4'd6;
  localparam logic [3:0] ALU_CTRL_DIV   = 4'd9;

  // ALU control codes 6..9 map onto the md op encoding in order.
  function automatic logic [1:0] alu_ctrl_to_op(input logic [3:0] ctrl);
    logic [3:0] w_off;
    w_off = ctrl - ALU_CTRL_MULTU;
    return w_off[1:0];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module : hilo_muldiv_if
// Brief  : Request, move-to and result signals of the HI/LO mul/div unit.
// Rev    : 1.0  initial release
// ============================================================================
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_divstep.sv
`default_nettype none
// ============================================================================
// Module : md_divstep
// Brief  : One combinational restoring-division step.
// Rev    : 1.0  initial release
// ============================================================================
module md_divstep #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH:0]   i_rem,
  input  wire logic [WIDTH-1:0] i_divisor,
  input  wire logic             i_bit,
  output logic      [WIDTH:0]   o_rem,
  output logic                  o_qbit
);
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH+1:0] w_div_ext;

  assign w_trial   = {i_rem, i_bit};
  assign w_div_ext = {2'b00, i_divisor};
  assign o_qbit    = (w_trial >= w_div_ext);
  assign o_rem     = o_qbit ? (WIDTH+1)'(w_trial - w_div_ext) : (WIDTH+1)'(w_trial);
endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module : hilo_muldiv
// Brief  : Iterative multiply/divide unit owning the HI/LO register pair.
// Rev    : 1.0  initial release
// ============================================================================
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  hilo_muldiv_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int              CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_mul_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_step_rem;
  logic               w_step_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_signed = op_is_signed(bus.op);
  assign w_neg_a  = w_signed & bus.src_a[WIDTH-1];
  assign w_neg_b  = w_signed & bus.src_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -bus.src_a : bus.src_a;
  assign w_abs_b  = w_neg_b ? -bus.src_b : bus.src_b;

  // Shift-add: upper half accumulates with carry, multiplier drains from the bottom.
  assign w_mul_addend = r_acc[0] ? r_b : '0;
  assign w_mul_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_addend};

  md_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .i_rem     (r_rem),
    .i_divisor (r_b),
    .i_bit     (r_q[WIDTH-1]),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  assign w_prod    = r_neg_q ? -r_acc : r_acc;
  assign w_quo     = r_neg_q ? -r_q : r_q;
  assign w_rem_fix = WIDTH'(r_neg_r ? -r_rem : r_rem);
  assign w_fix_hi  = r_is_div ? w_rem_fix : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo  = r_is_div ? w_quo     : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.hi_we) r_hi <= bus.wdata;
      if (bus.lo_we) r_lo <= bus.wdata;
      // Flush also swallows a start presented in IDLE on the same edge.
      if (bus.flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
              r_q      <= w_abs_a;
              r_rem    <= '0;
              r_b      <= w_abs_b;
              r_is_div <= op_is_div(bus.op);
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_neg_r  <= w_neg_a;
              r_cnt    <= '0;
              r_state  <= S_CALC;
            end
          end
          S_CALC: begin
            if (r_is_div) begin
              r_rem <= w_step_rem;
              r_q   <= {r_q[WIDTH-2:0], w_step_q};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == c_last) r_state <= S_FIX;
          end
          S_FIX: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module : tb_hilo_muldiv
// Brief  : Self-checking bench for hilo_muldiv against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0: return {32'h0, a} * {32'h0, b};
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int rs_from, input int rs_to, input int mtlo_at,
                        output logic [63:0] res, output int nbusy, output int tdone, output int ndone);
    nbusy = 0; tdone = -1; ndone = 0; res = '0;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        tdone = k;
        res = {bus.hi, bus.lo};
      end
      bus.start = (k >= rs_from) && (k <= rs_to);
      if (bus.start) begin
        bus.op    = 2'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end
      bus.flush = (k == flush_at);
      bus.lo_we = (k == mtlo_at);
      bus.wdata = 32'hDEAD_BEEF;
    end
    bus.start = 1'b0; bus.flush = 1'b0; bus.lo_we = 1'b0;
  endtask

  logic [1:0]  d_op  [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3};
  logic [31:0] d_a   [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9,
                             32'd7, 32'd5, 32'hFFFF_FFF9, 32'h8000_0000};
  logic [31:0] d_b   [9] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd2, 32'd2,
                             32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF};
  logic [63:0] d_exp [9] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
                             64'h4000_0000_0000_0000, 64'h0000_0001_0000_0003,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD,
                             64'h0000_0005_FFFF_FFFF, 64'hFFFF_FFF9_0000_0001,
                             64'h0000_0000_8000_0000};

  initial begin
    logic [63:0] res;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int nbusy, tdone, ndone, seen_done;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], -1, -1, -2, -1, res, nbusy, tdone, ndone);
      check($sformatf("dir%0d_result", i), res, d_exp[i]);
      check($sformatf("dir%0d_timing", i), {32'(nbusy), 16'(tdone), 16'(ndone)}, {32'd33, 16'd34, 16'd1});
      check($sformatf("dir%0d_hold", i), {bus.hi, bus.lo}, d_exp[i]);
    end

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        2:       rb = 32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, -1, -1, -2, -1, res, nbusy, tdone, ndone);
      check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), res, ref_model(rop, ra, rb));
      check($sformatf("rand%0d_done", i), 64'(ndone), 64'd1);
    end

    // Preload HI/LO, then flush a divide mid-flight.
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000_00BB;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("preload", {bus.hi, bus.lo}, 64'h0000_00AA_0000_00BB);
    run_op(MD_DIV, 32'd100, 32'd7, 10, -1, -2, -1, res, nbusy, tdone, ndone);
    check("flush_busy_cycles", 64'(nbusy), 64'd10);
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_hilo_kept", {bus.hi, bus.lo}, 64'h0000_00AA_0000_00BB);

    ra = $urandom; rb = $urandom;
    run_op(MD_MULT, ra, rb, -1, 5, 12, -1, res, nbusy, tdone, ndone);
    check("restart_ignored_result", res, ref_model(MD_MULT, ra, rb));
    check("restart_ignored_timing", {32'(nbusy), 16'(tdone), 16'(ndone)}, {32'd33, 16'd34, 16'd1});

    run_op(MD_DIVU, 32'd100, 32'd7, -1, -1, -2, 33, res, nbusy, tdone, ndone);
    check("mtlo_on_fix_result", res, 64'h0000_0002_0000_000E);
    check("mtlo_on_fix_hold", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.op = MD_MULTU; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midop_reset", {bus.hi, bus.lo, 30'h0, bus.busy, bus.done}, 96'h0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen_done++;
    end
    check("midop_reset_discarded", 64'(seen_done), 64'd0);

    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_idle", {bus.hi, bus.lo}, 64'h0000_1234_0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
